// File: rtl/microwave_timer_pkg.sv
// Shared definitions for the microwave cook timer: FSM states and BCD constants.
package microwave_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ZERO   = 4'd0;
  localparam logic [3:0] BCD_FIVE   = 4'd5;
  localparam logic [3:0] BCD_NINE   = 4'd9;
  localparam int         NUM_DIGITS = 4;

  // Digit order is sec_ones(0), sec_tens(1), min_ones(2), min_tens(3).
  // Only sec_tens wraps to 5; the minutes-tens wrap value is never used
  // because the count stops at 0000.
  function automatic logic [3:0] digit_wrap(input int idx);
    return (idx == 1) ? BCD_FIVE : BCD_NINE;
  endfunction

endpackage

// File: rtl/microwave_timer_bcd_digit_dec.sv
// One BCD digit of the countdown chain: decrements when a borrow arrives,
// wrapping to the supplied value and passing the borrow on when at zero.
module bcd_digit_dec
  import microwave_timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  input  logic [3:0] wrap,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  // Borrow-driven decrement of a single digit
  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == BCD_ZERO) begin
        digit_next = wrap;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time countdown: keypad entry into an MM:SS BCD register, one decrement
// per prescaled second while the magnetron is on, and a done flag back to the
// magnetron controller.
module microwave_timer
  import microwave_timer_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int CNT_W    = 7
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clearn,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] presc_reg, presc_next;
  logic             timer_done_reg, timer_done_next;
  logic [3:0]       digits_reg  [NUM_DIGITS];
  logic [3:0]       digits_next [NUM_DIGITS];
  logic [3:0]       dec_digit   [NUM_DIGITS];
  logic [NUM_DIGITS:0] borrow;
  logic             tick;
  logic             time_zero;
  logic             dec_zero;
  logic             shift_en;

  // The chain always computes "time minus one"; the FSM decides when to use it.
  // A borrow out of the top digit means the time is 0000, so nothing is applied.
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit_dec u_dec (
        .digit      (digits_reg[gi]),
        .borrow_in  (borrow[gi]),
        .wrap       (digit_wrap(gi)),
        .digit_next (dec_digit[gi]),
        .borrow_out (borrow[gi+1])
      );

      // Per-digit time register
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          digits_reg[gi] <= BCD_ZERO;
        end else begin
          digits_reg[gi] <= digits_next[gi];
        end
      end
    end
  endgenerate

  assign time_zero = (digits_reg[0] == BCD_ZERO) && (digits_reg[1] == BCD_ZERO) &&
                     (digits_reg[2] == BCD_ZERO) && (digits_reg[3] == BCD_ZERO);
  assign dec_zero  = (dec_digit[0] == BCD_ZERO) && (dec_digit[1] == BCD_ZERO) &&
                     (dec_digit[2] == BCD_ZERO) && (dec_digit[3] == BCD_ZERO);
  assign tick      = (state_reg == S_RUN) && mag_on && (presc_reg == PRESC_LAST);
  assign shift_en  = (state_reg == S_IDLE) && load && !mag_on && (digit <= BCD_NINE);

  // Next-state, prescaler and time register update; clearn overrides everything
  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits_next[i] = digits_reg[i];
    end

    case (state_reg)
      S_IDLE: begin
        if (mag_on) begin
          // An empty timer goes straight to DONE so the magnetron stops at once
          state_next = time_zero ? S_DONE : S_RUN;
        end else if (shift_en) begin
          digits_next[3] = digits_reg[2];
          digits_next[2] = digits_reg[1];
          digits_next[1] = digits_reg[0];
          digits_next[0] = digit;
        end
      end
      S_RUN: begin
        // mag_on low pauses: prescaler keeps its partial second
        if (mag_on) begin
          if (tick) begin
            presc_next = '0;
            if (!borrow[NUM_DIGITS]) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_next[i] = dec_digit[i];
              end
              if (dec_zero) begin
                state_next = S_DONE;
              end
            end
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (!clearn) begin
      state_next = S_IDLE;
      presc_next = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_next[i] = BCD_ZERO;
      end
    end

    // Registered so timer_done rises on the same edge the time reaches 0000
    timer_done_next = (state_next == S_DONE);
  end

  // State, prescaler and done flag registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      presc_reg      <= '0;
      timer_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      presc_reg      <= presc_next;
      timer_done_reg <= timer_done_next;
    end
  end

  assign min_tens   = digits_reg[3];
  assign min_ones   = digits_reg[2];
  assign sec_tens   = digits_reg[1];
  assign sec_ones   = digits_reg[0];
  assign timer_done = timer_done_reg;

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer: directed vector table, hand-written pause and
// async-reset sequences, then random stimulus against a decimal-arithmetic model.
module tb_microwave_timer;

  localparam int TICK = 4;

  logic       clk;
  logic       rstn;
  logic       clearn;
  logic       load;
  logic [3:0] digit;
  logic       mag_on;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: time held as whole minutes and seconds, mode 0/1/2 for
  // idle/counting/finished, and a count of cycles spent counting.
  int m_mode, m_mins, m_secs, m_runs;

  microwave_timer #(.TICK_DIV(TICK), .CNT_W(7)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clearn     (clearn),
    .load       (load),
    .digit      (digit),
    .mag_on     (mag_on),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        clearn;
    logic        load;
    logic [3:0]  digit;
    logic        mag_on;
    logic [15:0] exp_time;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic l, input logic [3:0] d,
                              input logic m, input logic [15:0] t, input logic dn);
    vec_t v;
    v.clearn = c; v.load = l; v.digit = d; v.mag_on = m;
    v.exp_time = t; v.exp_done = dn;
    return v;
  endfunction

  function automatic logic [16:0] dut_bus();
    return {min_tens, min_ones, sec_tens, sec_ones, timer_done};
  endfunction

  function automatic logic [16:0] model_bus();
    return {4'(m_mins / 10), 4'(m_mins % 10), 4'(m_secs / 10), 4'(m_secs % 10),
            (m_mode == 2)};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got time=%h done=%b, want time=%h done=%b",
               name, act[16:1], act[0], exp[16:1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_mins = 0; m_secs = 0; m_runs = 0;
  endtask

  task automatic model_step(input logic c, input logic l, input logic [3:0] d, input logic m);
    int v;
    if (!c) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (m) begin
        m_mode = (m_mins == 0 && m_secs == 0) ? 2 : 1;
      end else if (l && d <= 4'd9) begin
        v = ((m_mins * 100 + m_secs) * 10 + int'(d)) % 10000;
        m_mins = v / 100;
        m_secs = v % 100;
      end
    end else if (m_mode == 1 && m) begin
      if (m_runs % TICK == TICK - 1) begin
        if (m_secs > 0) m_secs--;
        else begin
          m_mins--;
          m_secs = 59;
        end
        if (m_mins == 0 && m_secs == 0) m_mode = 2;
      end
      m_runs++;
    end
  endtask

  // One clock transaction: drive, clock, advance model, compare, log
  task automatic step(input logic c, input logic l, input logic [3:0] d, input logic m);
    clearn = c; load = l; digit = d; mag_on = m;
    @(posedge clk);
    model_step(c, l, d, m);
    #1;
    cyc++;
    $display("cyc %0d clearn=%b load=%b digit=%h mag_on=%b -> %h%h:%h%h done=%b",
             cyc, c, l, d, m, min_tens, min_ones, sec_tens, sec_ones, timer_done);
    check("model", dut_bus(), model_bus());
  endtask

  initial begin
    rstn = 1'b0; clearn = 1'b1; load = 1'b0; digit = 4'd0; mag_on = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_bus(), 17'h0);
    rstn = 1'b1;

    // Directed table: clearn, load, digit, mag_on, expected MMSS, expected done
    vecs.push_back(mk(1, 1, 4'd1, 0, 16'h0001, 0));
    vecs.push_back(mk(1, 1, 4'd3, 0, 16'h0013, 0));
    vecs.push_back(mk(1, 1, 4'd0, 0, 16'h0130, 0));
    vecs.push_back(mk(1, 0, 4'd0, 0, 16'h0130, 0));
    vecs.push_back(mk(1, 1, 4'hA, 0, 16'h0130, 0));   // invalid digit ignored
    vecs.push_back(mk(0, 0, 4'd0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 4'd2, 0, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0002, 0));   // enter RUN
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0001, 0));   // first tick
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0001, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0001, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0001, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0000, 1));   // zero and done together
    vecs.push_back(mk(1, 1, 4'd5, 1, 16'h0000, 1));
    vecs.push_back(mk(1, 0, 4'd0, 0, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 4'd0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 4'd1, 0, 16'h0001, 0));   // 01:00 -> 00:59
    vecs.push_back(mk(1, 1, 4'd0, 0, 16'h0010, 0));
    vecs.push_back(mk(1, 1, 4'd0, 0, 16'h0100, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0100, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0059, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 4'd1, 0, 16'h0001, 0));   // 10:00 -> 09:59
    vecs.push_back(mk(1, 1, 4'd0, 0, 16'h0010, 0));
    vecs.push_back(mk(1, 1, 4'd0, 0, 16'h0100, 0));
    vecs.push_back(mk(1, 1, 4'd0, 0, 16'h1000, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 1, 4'd7, 1, 16'h1000, 0)); // load dropped
    vecs.push_back(mk(1, 1, 4'd7, 1, 16'h0959, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0000, 1));   // empty timer -> done
    vecs.push_back(mk(0, 0, 4'd0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 4'd9, 0, 16'h0009, 0));   // clear beats tick
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 4'd0, 1, 16'h0009, 0));
    vecs.push_back(mk(0, 0, 4'd0, 1, 16'h0000, 0));
    vecs.push_back(mk(1, 0, 4'd0, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 4'd3, 0, 16'h0003, 0));   // back in IDLE
    vecs.push_back(mk(0, 0, 4'd0, 0, 16'h0000, 0));

    foreach (vecs[i]) begin
      step(vecs[i].clearn, vecs[i].load, vecs[i].digit, vecs[i].mag_on);
      check($sformatf("vec%0d", i), dut_bus(), {vecs[i].exp_time, vecs[i].exp_done});
    end

    // Pause keeps the partial second
    step(1, 1, 4'd5, 0);
    step(1, 0, 4'd0, 1);                // enter RUN
    step(1, 0, 4'd0, 1);                // one prescaler count
    for (int i = 0; i < 10; i++) step(1, 0, 4'd0, 0);
    check("pause_hold", dut_bus(), {16'h0005, 1'b0});
    step(1, 0, 4'd0, 1);
    step(1, 0, 4'd0, 1);
    check("resume_partial", dut_bus(), {16'h0005, 1'b0});
    step(1, 0, 4'd0, 1);
    check("resume_tick", dut_bus(), {16'h0004, 1'b0});
    step(0, 0, 4'd0, 0);

    // Asynchronous reset mid-run
    step(1, 1, 4'd9, 0);
    step(1, 0, 4'd0, 1);
    step(1, 0, 4'd0, 1);
    step(1, 0, 4'd0, 1);
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_bus(), 17'h0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) step(1, 0, 4'd0, 0);
    check("after_reset_idle", dut_bus(), 17'h0);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 9) < 4,
           4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
